serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives start/A/B; the slave returns D/Bo/V with busy/done.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             Bo;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B,
    input  D, Bo, V, busy, done
  );

  modport slave (
    input  start, A, B,
    output D, Bo, V, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B, LSB first, one borrow cell per clock.
// Bo flags unsigned borrow, V flags signed overflow.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt;
  logic             br, a_msb, b_msb;
  logic             bo_q, v_q;
  logic             busy, done;

  logic             accept, last;
  logic             d_bit, br_nx;
  logic [WIDTH-1:0] r_nx;

  assign accept = bus.start &&
                  (state == S_IDLE || state == S_DONE);
  assign last   = (cnt == CW'(WIDTH - 1));

  assign d_bit = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nx = (~a_sr[0] & b_sr[0]) |
                 (~(a_sr[0] ^ b_sr[0]) & br);
  assign r_nx  = {d_bit, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (bus.start) state_nx = S_RUN;
      S_RUN:  if (last)      state_nx = S_DONE;
      S_DONE: state_nx = bus.start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Results only move on the final bit-step; they hold through later runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      d_q   <= '0;
      bo_q  <= 1'b0;
      v_q   <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.A;
      b_sr  <= bus.B;
      a_msb <= bus.A[WIDTH-1];
      b_msb <= bus.B[WIDTH-1];
      r_sr  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
    end else if (state == S_RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_nx;
      br   <= br_nx;
      cnt  <= cnt + 1'b1;
      if (last) begin
        d_q  <= r_nx;
        bo_q <= br_nx;
        v_q  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
      end
    end
  end

  assign bus.D    = d_q;
  assign bus.Bo   = bo_q;
  assign bus.V    = v_q;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4.
// Stimulus pushes expectations; a negedge monitor pops them on done.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string name, int act, int want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(int d, int bo, int v);
    exp_t e;
    e.d  = d[W-1:0];
    e.bo = bo[0];
    e.v  = v[0];
    return e;
  endfunction

  function automatic exp_t model(int a, int b);
    exp_t         e;
    logic [W-1:0] av, bv, dv;
    av   = a[W-1:0];
    bv   = b[W-1:0];
    dv   = av - bv;
    e.d  = dv;
    e.bo = (a < b);
    e.v  = (av[W-1] ^ bv[W-1]) & (av[W-1] ^ dv[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy_done_overlap",
            int'(bus.busy & bus.done), 0);
      if (bus.done === 1'b1) begin
        check("sb_nonempty_on_done",
              int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("D",  int'(bus.D),  int'(e.d));
          check("Bo", int'(bus.Bo), int'(e.bo));
          check("V",  int'(bus.V),  int'(e.v));
        end
      end
    end
  end

  task automatic run_op(int a, int b, exp_t e);
    int nb;
    bit seen;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = a[W-1:0];
    bus.B     = b[W-1:0];
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.start = 1'b0;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) nb++;
    end
    check("done_seen", int'(seen), 1);
    check("busy_cycles", nb, W);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_D"},    int'(bus.D),    0);
    check({tag, "_Bo"},   int'(bus.Bo),   0);
    check({tag, "_V"},    int'(bus.V),    0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    int  n;
    bit  seen;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run_op(5, 3, mk(4'b0010, 0, 0));
    run_op(3, 5, mk(4'b1110, 1, 0));
    run_op(0, 0, mk(0, 0, 0));
    run_op(4'b0111, 4'b1000, mk(4'b1111, 1, 1));
    run_op(4'b1000, 4'b0001, mk(4'b0111, 0, 1));

    // start held through RUN with operands churning
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 4'd5;
    bus.B     = 4'd3;
    @(posedge clk);
    sb.push_back(mk(2, 0, 0));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      bus.A = W'($urandom_range(15));
      bus.B = W'($urandom_range(15));
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else @(posedge clk);
    end
    check("hold_first_done", int'(seen), 1);
    bus.A = 4'd12;
    bus.B = 4'd4;
    sb.push_back(mk(8, 0, 0));
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      n++;
      if (n == 1) begin
        #1;
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("b2b_done_seen", int'(seen), 1);
    check("b2b_edges", n, W + 1);

    // reset lands mid-RUN; the operation must vanish
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 4'd9;
    bus.B     = 4'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrun_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_done_after_reset", int'(bus.done), 0);
    end
    run_op(9, 2, mk(7, 0, 1));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(a, b, model(a, b));

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
